// File: rtl/lspc_vram_port.sv
// LSPC CPU register block with queued VRAM writes, auto-increment and read prefetch.
// Optional define LSPC_VRAM_STATUS_EN exposes queue/latch status at register 7.
module lspc_vram_port #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1
) (
    input  logic              CLK_24M,
    input  logic              RESET,
    input  logic [2:0]        M68K_ADDR,
    input  logic [15:0]       M68K_DATA,
    input  logic              LSPOE,
    input  logic              LSPWE,
    input  logic              VMODE,
    input  logic [8:0]        RASTERC,
    input  logic [2:0]        AA_COUNT,
    input  logic              VRAM_SLOT,
    input  logic [15:0]       VRAM_RDATA,
    output logic [ADDR_W-1:0] VRAM_ADDR,
    output logic [15:0]       VRAM_WDATA,
    output logic              VRAM_WE,
    output logic              VRAM_RD,
    output logic [15:0]       CPU_DATA_OUT,
    output logic [15:0]       REG_VRAMMOD,
    output logic [7:0]        AA_SPEED,
    output logic [2:0]        TIMER_MODE,
    output logic              TIMER_IRQ_EN,
    output logic              AA_DISABLE,
    output logic              TIMER_STOP,
    output logic              WR_TIMER_HIGH,
    output logic              WR_TIMER_LOW,
    output logic              WR_IRQ_ACK,
    output logic              FIFO_FULL,
    output logic              BUSY
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 16;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

    logic [2:0]        we_sync_q, oe_sync_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       mod_q, mod_d;
    logic [12:0]       mode_q, mode_d;
    logic              tstop_q, tstop_d;
    logic              th_q, tl_q, ack_q;
    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;
    logic              valid_q, valid_d;
    logic              disc_q, disc_d;
    logic [15:0]       latch_q, latch_d;
    logic [15:0]       cpu_q, cpu_d;
    logic [1:0]        lat_q, lat_d;
    state_t            state_q, state_d;

    logic we_ev, oe_ev, ev_addr, ev_rw, full, push, pop, vram_we, vram_rd;
    logic done, load;
    logic [EW-1:0] head;
    logic [15:0]   lspc_rd, rd_mux;

    // Falling edge of the synchronised strobe, one cycle wide.
    assign we_ev   = we_sync_q[2] & ~we_sync_q[1];
    assign oe_ev   = oe_sync_q[2] & ~oe_sync_q[1];
    assign ev_addr = we_ev && (M68K_ADDR == 3'd0);
    assign ev_rw   = we_ev && (M68K_ADDR == 3'd1);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push    = ev_rw & ~full;
    assign head    = fifo_q[rptr_q];

    assign vram_we = ~RESET & VRAM_SLOT & (state_q == IDLE) & (count_q != '0);
    assign vram_rd = ~RESET & VRAM_SLOT & (state_q == IDLE) & (count_q == '0) & pend_q;
    assign pop     = vram_we;

    always_comb begin
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        mod_d   = mod_q;
        mode_d  = mode_q;
        tstop_d = tstop_q;
        if (ev_addr) begin
            addr_d = M68K_DATA[ADDR_W-1:0];
            ovf_d  = 1'b0;
        end else if (push) begin
            addr_d = addr_q + mod_q[ADDR_W-1:0];
        end else if (ev_rw) begin
            ovf_d = 1'b1;
        end
        if (we_ev && M68K_ADDR == 3'd2) mod_d = M68K_DATA;
        if (we_ev && M68K_ADDR == 3'd3) mode_d = M68K_DATA[15:3];
        if (we_ev && M68K_ADDR == 3'd7) tstop_d = M68K_DATA[0];

        count_d = count_q + CW'(push) - CW'(pop);
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
        pend_d  = (pend_q & ~vram_rd) | ev_addr | ev_rw;

        state_d = state_q;
        lat_d   = lat_q;
        disc_d  = disc_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (vram_rd) begin
                    state_d = READ_WAIT;
                    lat_d   = 2'd1;
                    disc_d  = ev_addr | ev_rw;
                end
            end
            READ_WAIT: begin
                if (ev_addr | ev_rw) disc_d = 1'b1;
                if (lat_q == 2'(READ_LAT)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A relocating write during the wait makes the returning word stale.
        load    = done & ~disc_q & ~ev_addr & ~ev_rw;
        latch_d = load ? VRAM_RDATA : latch_q;
        valid_d = ev_addr ? 1'b0 : (load | valid_q);
        cpu_d   = oe_ev ? rd_mux : cpu_q;
    end

    assign lspc_rd = {RASTERC, 3'b000, VMODE, AA_COUNT};

    always_comb begin
        rd_mux = '0;
        case (M68K_ADDR)
            3'd0, 3'd1, 3'd4, 3'd5: rd_mux = latch_q;
            3'd2, 3'd6:             rd_mux = mod_q;
            3'd3:                   rd_mux = lspc_rd;
`ifdef LSPC_VRAM_STATUS_EN
            3'd7: rd_mux = {8'h00, 5'(count_q), ovf_q, full, valid_q};
`else
            3'd7: rd_mux = lspc_rd;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            we_sync_q <= '0;
            oe_sync_q <= '0;
            addr_q    <= '0;
            mod_q     <= '0;
            mode_q    <= '0;
            tstop_q   <= 1'b0;
            th_q      <= 1'b0;
            tl_q      <= 1'b0;
            ack_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            disc_q    <= 1'b0;
            latch_q   <= '0;
            cpu_q     <= '0;
            lat_q     <= '0;
            state_q   <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            we_sync_q <= {we_sync_q[1:0], LSPWE};
            oe_sync_q <= {oe_sync_q[1:0], LSPOE};
            addr_q    <= addr_d;
            mod_q     <= mod_d;
            mode_q    <= mode_d;
            tstop_q   <= tstop_d;
            th_q      <= we_ev && (M68K_ADDR == 3'd4);
            tl_q      <= we_ev && (M68K_ADDR == 3'd5);
            ack_q     <= we_ev && (M68K_ADDR == 3'd6);
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            disc_q    <= disc_d;
            latch_q   <= latch_d;
            cpu_q     <= cpu_d;
            lat_q     <= lat_d;
            state_q   <= state_d;
            if (push) fifo_q[wptr_q] <= {addr_q, M68K_DATA};
        end
    end

    assign VRAM_WE       = vram_we;
    assign VRAM_RD       = vram_rd;
    assign VRAM_ADDR     = vram_we ? head[EW-1:16] : (vram_rd ? addr_q : '0);
    assign VRAM_WDATA    = vram_we ? head[15:0] : 16'h0000;
    assign CPU_DATA_OUT  = cpu_q;
    assign REG_VRAMMOD   = mod_q;
    assign AA_SPEED      = mode_q[12:5];
    assign TIMER_MODE    = mode_q[4:2];
    assign TIMER_IRQ_EN  = mode_q[1];
    assign AA_DISABLE    = mode_q[0];
    assign TIMER_STOP    = tstop_q;
    assign WR_TIMER_HIGH = th_q;
    assign WR_TIMER_LOW  = tl_q;
    assign WR_IRQ_ACK    = ack_q;
    assign FIFO_FULL     = full;
    assign BUSY          = (count_q != '0) | pend_q | (state_q != IDLE);
endmodule

// File: tb/tb_lspc_vram_port.sv
// Scoreboard bench for lspc_vram_port: random CPU traffic, random slots,
// behavioural register/VRAM model, separate write and read-back monitors.
module tb_lspc_vram_port;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic [2:0]    M68K_ADDR = '0;
    logic [15:0]   M68K_DATA = '0;
    logic          LSPOE = 1'b1;
    logic          LSPWE = 1'b1;
    logic          VMODE = 1'b0;
    logic [8:0]    RASTERC = '0;
    logic [2:0]    AA_COUNT = '0;
    logic          VRAM_SLOT = 1'b0;
    logic [15:0]   VRAM_RDATA = '0;
    logic [AW-1:0] VRAM_ADDR;
    logic [15:0]   VRAM_WDATA, CPU_DATA_OUT, REG_VRAMMOD;
    logic          VRAM_WE, VRAM_RD;
    logic [7:0]    AA_SPEED;
    logic [2:0]    TIMER_MODE;
    logic          TIMER_IRQ_EN, AA_DISABLE, TIMER_STOP;
    logic          WR_TIMER_HIGH, WR_TIMER_LOW, WR_IRQ_ACK, FIFO_FULL, BUSY;

    lspc_vram_port #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .READ_LAT(LAT)) dut (
        .CLK_24M(clk), .RESET(RESET), .M68K_ADDR(M68K_ADDR), .M68K_DATA(M68K_DATA),
        .LSPOE(LSPOE), .LSPWE(LSPWE), .VMODE(VMODE), .RASTERC(RASTERC),
        .AA_COUNT(AA_COUNT), .VRAM_SLOT(VRAM_SLOT), .VRAM_RDATA(VRAM_RDATA),
        .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA), .VRAM_WE(VRAM_WE),
        .VRAM_RD(VRAM_RD), .CPU_DATA_OUT(CPU_DATA_OUT), .REG_VRAMMOD(REG_VRAMMOD),
        .AA_SPEED(AA_SPEED), .TIMER_MODE(TIMER_MODE), .TIMER_IRQ_EN(TIMER_IRQ_EN),
        .AA_DISABLE(AA_DISABLE), .TIMER_STOP(TIMER_STOP),
        .WR_TIMER_HIGH(WR_TIMER_HIGH), .WR_TIMER_LOW(WR_TIMER_LOW),
        .WR_IRQ_ACK(WR_IRQ_ACK), .FIFO_FULL(FIFO_FULL), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;

    int total = 0;
    int bad = 0;
    wr_t exp_wq[$];
    logic [15:0] rd_exp_q[$];
    logic [15:0] refmem[int];
    logic [15:0] vmem[int];
    logic [15:0] m_addr, m_mod, m_latch, m_lspc;
    bit m_valid, m_pend, m_ovf, m_ts;
    bit slot_en = 0;
    int lat_left = 0;
    logic [15:0] rd_val;
    int n_irq = 0, n_th = 0, n_tl = 0;
    wr_t e_w;
    event oe_done;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0, a} * 32'h9E37;
        return p[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] rget(input logic [15:0] a);
        return refmem.exists(int'(a)) ? refmem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] vget(input logic [15:0] a);
        return vmem.exists(int'(a)) ? vmem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        logic [15:0] mode_rd;
        mode_rd = {RASTERC, 3'b000, VMODE, AA_COUNT};
        case (a)
            3'd0, 3'd1, 3'd4, 3'd5: return m_latch;
            3'd2, 3'd6: return m_mod;
            3'd3: return mode_rd;
`ifdef LSPC_VRAM_STATUS_EN
            default: return {8'h00, 5'(exp_wq.size()), m_ovf,
                             exp_wq.size() == DEPTH, m_valid};
`else
            default: return mode_rd;
`endif
        endcase
    endfunction

    // Slot generator and VRAM read-data environment.
    initial forever begin
        @(posedge clk); #1;
        VRAM_SLOT = slot_en && ($urandom_range(0, 2) == 0);
        if (lat_left > 0) begin
            lat_left--;
            VRAM_RDATA = (lat_left == 0) ? rd_val : 16'($urandom);
        end else begin
            VRAM_RDATA = 16'($urandom);
        end
    end

    // VRAM-side monitor: write scoreboard and read capture.
    always @(negedge clk) begin
        if (VRAM_WE) begin
            check("we_in_slot", VRAM_SLOT, 1);
            if (exp_wq.size() == 0) check("we_unexpected", VRAM_WE, 0);
            else begin
                e_w = exp_wq.pop_front();
                check("we_addr", VRAM_ADDR, e_w.a);
                check("we_data", VRAM_WDATA, e_w.d);
            end
            vmem[int'(VRAM_ADDR)] = VRAM_WDATA;
        end
        if (VRAM_RD) begin
            check("rd_in_slot", VRAM_SLOT, 1);
            lat_left = LAT;
            rd_val = vget(VRAM_ADDR);
        end
        if (WR_IRQ_ACK) n_irq++;
        if (WR_TIMER_HIGH) n_th++;
        if (WR_TIMER_LOW) n_tl++;
    end

    // CPU read-back monitor.
    initial forever begin
        @(oe_done);
        if (rd_exp_q.size() == 0) check("cpu_rd_unexpected", rd_exp_q.size(), 1);
        else check("cpu_rd", CPU_DATA_OUT, rd_exp_q.pop_front());
    end

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        case (a)
            3'd0: begin m_addr = d; m_valid = 0; m_pend = 1; m_ovf = 0; end
            3'd1: begin
                m_pend = 1;
                if (!slot_en && exp_wq.size() == DEPTH) m_ovf = 1;
                else begin
                    exp_wq.push_back('{a: m_addr, d: d});
                    refmem[int'(m_addr)] = d;
                    m_addr = m_addr + m_mod;
                end
            end
            3'd2: m_mod = d;
            3'd3: m_lspc = d;
            3'd7: m_ts = d[0];
            default: ;
        endcase
        @(negedge clk);
        M68K_ADDR = a; M68K_DATA = d; LSPWE = 1'b0;
        repeat (4) @(negedge clk);
        LSPWE = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [2:0] a);
        @(negedge clk);
        RASTERC = 9'($urandom); VMODE = 1'($urandom); AA_COUNT = 3'($urandom);
        M68K_ADDR = a;
        rd_exp_q.push_back(exp_read(a));
        LSPOE = 1'b0;
        repeat (4) @(negedge clk);
        LSPOE = 1'b1;
        -> oe_done;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        slot_en = 1;
        @(negedge clk);
        while (BUSY && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check("idle_timeout", BUSY, 0);
        if (m_pend) begin m_latch = rget(m_addr); m_valid = 1; m_pend = 0; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        RESET = 1'b1;
        exp_wq.delete();
        lat_left = 0;
        slot_en = 1;
        repeat (3) @(posedge clk); #1;
        RESET = 1'b0;
        m_addr = 0; m_mod = 0; m_latch = 0; m_lspc = 0;
        m_valid = 0; m_pend = 0; m_ovf = 0; m_ts = 0;
        @(negedge clk);
        check("rst_outs", {CPU_DATA_OUT, REG_VRAMMOD, AA_SPEED, TIMER_MODE,
              TIMER_IRQ_EN, AA_DISABLE, TIMER_STOP, WR_TIMER_HIGH, WR_TIMER_LOW,
              WR_IRQ_ACK}, 0);
        check("rst_full_busy", {FIFO_FULL, BUSY}, 0);
        check("rst_vram", {VRAM_WE, VRAM_RD, VRAM_ADDR, VRAM_WDATA}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [2:0] ra;
        int op;
        repeat (3) @(posedge clk);
        do_reset();

        // Sequential writes with modulo 1
        cpu_wr(3'd2, 16'h0001);
        cpu_wr(3'd0, 16'h7000);
        cpu_wr(3'd1, 16'h1111);
        cpu_wr(3'd1, 16'h2222);
        wait_idle();
        cpu_rd(3'd0);
        cpu_rd(3'd2);

        // Address wrap
        cpu_wr(3'd2, 16'h0020);
        cpu_wr(3'd0, 16'hFFF0);
        cpu_wr(3'd1, 16'hABCD);
        wait_idle();
        cpu_rd(3'd1);

        // Prefetch read-back
        vmem[16'h8000] = 16'h5A5A;
        refmem[16'h8000] = 16'h5A5A;
        cpu_wr(3'd0, 16'h8000);
        wait_idle();
        cpu_rd(3'd0);
        cpu_rd(3'd4);

        // Mode register and strobe pulses
        cpu_wr(3'd3, 16'h12F8);
        check("aa_speed", AA_SPEED, 8'h12);
        check("timer_mode", TIMER_MODE, 3'd7);
        check("irq_en_aa_dis", {TIMER_IRQ_EN, AA_DISABLE}, 2'b11);
        cpu_rd(3'd3);
        cpu_rd(3'd7);
        n_irq = 0; n_th = 0; n_tl = 0;
        cpu_wr(3'd6, 16'h0000);
        check("irq_ack_pulses", n_irq, 1);
        cpu_wr(3'd4, 16'h1234);
        cpu_wr(3'd5, 16'h5678);
        check("timer_pulses", {n_th[7:0], n_tl[7:0], n_irq[7:0]}, 24'h010101);
        cpu_wr(3'd7, 16'h0001);
        check("timer_stop", TIMER_STOP, 1);

        // Overflow with slots withheld
        cpu_wr(3'd2, 16'h0001);
        cpu_wr(3'd0, 16'h0100);
        wait_idle();
        slot_en = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) cpu_wr(3'd1, 16'($urandom));
        check("ovf_full", FIFO_FULL, 1);
        check("ovf_busy", BUSY, 1);
        cpu_rd(3'd7);
        wait_idle();
        check("ovf_drained_full", FIFO_FULL, 0);
        cpu_rd(3'd0);
        cpu_rd(3'd7);

        // Reset with a partly filled queue
        slot_en = 0;
        repeat (3) @(negedge clk);
        cpu_wr(3'd0, 16'h4000);
        for (int i = 0; i < 3; i++) cpu_wr(3'd1, 16'($urandom));
        check("pre_rst_busy", BUSY, 1);
        do_reset();
        repeat (30) @(negedge clk);
        check("post_rst_busy", BUSY, 0);
        cpu_rd(3'd0);
        cpu_rd(3'd7);

        // Random traffic
        cpu_wr(3'd0, 16'($urandom));
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                for (int n = 0; n < 400 && FIFO_FULL; n++) @(negedge clk);
                cpu_wr(3'd1, 16'($urandom));
            end else if (op == 5) begin
                cpu_wr(3'd0, 16'($urandom));
            end else if (op == 6) begin
                case ($urandom_range(0, 3))
                    0: cpu_wr(3'd2, 16'h0000);
                    1: cpu_wr(3'd2, 16'h0001);
                    2: cpu_wr(3'd2, 16'h0020);
                    default: cpu_wr(3'd2, 16'($urandom));
                endcase
            end else if (op == 7) begin
                cpu_wr(3'd3, 16'($urandom));
            end else begin
                wait_idle();
                ra = 3'($urandom);
                cpu_rd(ra);
            end
        end
        wait_idle();
        cpu_rd(3'd0);
        check("wq_drained", exp_wq.size(), 0);
        check("rdq_drained", rd_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
